// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//
// Decode stage of a small MIPS-like pipeline. Splits the fetched word into
// fields, reads two operands from a 32-entry register file, produces the
// control bundle for execute and latches everything into the ID/EX register.
// A load-use interlock (Load_hazard) asks fetch to hold its PC and
// instruction while a bubble is inserted.
//
// Configuration macro: ID_BYPASS_EN
//   defined   : a write-back in the same cycle as a read of the same
//               nonzero register is forwarded to the read port.
//   undefined : same-cycle reads return the pre-write register contents.
//
// Ports
//   clk                     single clock, rising edge
//   ID_reset                synchronous active-high reset (outputs + regfile)
//   IF_valid, instruction   fetched word and its valid flag
//   ID_stall, ID_flush      hold / kill requests from downstream
//   RF_WE, RF_waddr, RF_wdata   write-back port into the register file
//   EX_rs_data, EX_rt_data, EX_imm   registered operands, sign-extended imm
//   EX_rs, EX_rt, EX_dest   registered register indices
//   EX_ALU_op, EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch,
//   EX_ALUSrc, EX_illegal   registered control bundle
//   Load_hazard             combinational load-use stall request to fetch
//
// ID/EX update priority: ID_reset > ID_flush > ID_stall > Load_hazard >
// normal latch (bubble when IF_valid is low).
// ---------------------------------------------------------------------------
module instruction_decode #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              ID_reset,
    input  logic              IF_valid,
    input  logic [31:0]       instruction,
    input  logic              ID_stall,
    input  logic              ID_flush,
    input  logic              RF_WE,
    input  logic [4:0]        RF_waddr,
    input  logic [DATA_W-1:0] RF_wdata,
    output logic [DATA_W-1:0] EX_rs_data,
    output logic [DATA_W-1:0] EX_rt_data,
    output logic [DATA_W-1:0] EX_imm,
    output logic [4:0]        EX_rs,
    output logic [4:0]        EX_rt,
    output logic [4:0]        EX_dest,
    output logic [2:0]        EX_ALU_op,
    output logic              EX_valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_Branch,
    output logic              EX_ALUSrc,
    output logic              EX_illegal,
    output logic              Load_hazard
);

    // Opcodes and R-type function codes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpBeq   = 6'h04;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    // ALU operation encoding seen by execute
    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluSlt = 3'd4;

    typedef struct packed {
        logic              valid;
        logic              illegal;
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
    } ex_t;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign funct  = instruction[5:0];
    assign imm16  = instruction[15:0];

    // ------------------------------------------------------------------
    // Register file: asynchronous reads, write on the clock edge
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    always_ff @(posedge clk) begin
        if (ID_reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RF_WE && (RF_waddr != 5'd0)) begin
            rf_q[RF_waddr] <= RF_wdata;
        end
    end

    always_comb begin
        rs_data = (rs == 5'd0) ? '0 : rf_q[rs];
        rt_data = (rt == 5'd0) ? '0 : rf_q[rt];
`ifdef ID_BYPASS_EN
        // Forward the write-back value so a same-cycle reader sees it
        if (RF_WE && (RF_waddr != 5'd0) && (RF_waddr == rs)) begin
            rs_data = RF_wdata;
        end
        if (RF_WE && (RF_waddr != 5'd0) && (RF_waddr == rt)) begin
            rt_data = RF_wdata;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [2:0] dec_alu_op;
    logic       dec_reg_write;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_alu_src;
    logic       dec_illegal;
    logic [4:0] dec_dest;
    logic       dec_reads_rt;

    always_comb begin
        dec_alu_op    = AluAdd;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_alu_src   = 1'b0;
        dec_illegal   = 1'b0;
        dec_dest      = 5'd0;
        dec_reads_rt  = 1'b0;

        case (opcode)
            OpRtype: begin
                dec_reads_rt  = 1'b1;
                dec_reg_write = 1'b1;
                dec_dest      = rd;
                case (funct)
                    FnAdd:   dec_alu_op = AluAdd;
                    FnSub:   dec_alu_op = AluSub;
                    FnAnd:   dec_alu_op = AluAnd;
                    FnOr:    dec_alu_op = AluOr;
                    FnSlt:   dec_alu_op = AluSlt;
                    default: begin
                        dec_illegal   = 1'b1;
                        dec_reg_write = 1'b0;
                        dec_dest      = 5'd0;
                    end
                endcase
            end
            OpLw: begin
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = rt;
            end
            OpSw: begin
                dec_reads_rt  = 1'b1;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OpAddi: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = rt;
            end
            OpBeq: begin
                dec_reads_rt = 1'b1;
                dec_branch   = 1'b1;
                dec_alu_op   = AluSub;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    ex_t ex_q;
    ex_t ex_d;
    ex_t ex_new;

    // Load-use interlock against the instruction currently in EX
    assign Load_hazard = ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                         ((ex_q.dest == rs) || ((ex_q.dest == rt) && dec_reads_rt)) &&
                         IF_valid;

    always_comb begin
        ex_new           = '0;
        ex_new.valid     = 1'b1;
        ex_new.illegal   = dec_illegal;
        ex_new.alu_op    = dec_alu_op;
        ex_new.reg_write = dec_reg_write;
        ex_new.mem_read  = dec_mem_read;
        ex_new.mem_write = dec_mem_write;
        ex_new.branch    = dec_branch;
        ex_new.alu_src   = dec_alu_src;
        ex_new.rs        = rs;
        ex_new.rt        = rt;
        ex_new.dest      = dec_dest;
        ex_new.imm       = {{(DATA_W-16){imm16[15]}}, imm16};
        ex_new.rs_data   = rs_data;
        ex_new.rt_data   = rt_data;
    end

    always_comb begin
        ex_d = ex_q;
        if (ID_reset || ID_flush) begin
            ex_d = '0;
        end else if (ID_stall) begin
            ex_d = ex_q;
        end else if (Load_hazard || !IF_valid) begin
            ex_d = '0;
        end else begin
            ex_d = ex_new;
        end
    end

    always_ff @(posedge clk) begin
        ex_q <= ex_d;
    end

    assign EX_valid    = ex_q.valid;
    assign EX_illegal  = ex_q.illegal;
    assign EX_ALU_op   = ex_q.alu_op;
    assign EX_RegWrite = ex_q.reg_write;
    assign EX_MemRead  = ex_q.mem_read;
    assign EX_MemWrite = ex_q.mem_write;
    assign EX_Branch   = ex_q.branch;
    assign EX_ALUSrc   = ex_q.alu_src;
    assign EX_rs       = ex_q.rs;
    assign EX_rt       = ex_q.rt;
    assign EX_dest     = ex_q.dest;
    assign EX_imm      = ex_q.imm;
    assign EX_rs_data  = ex_q.rs_data;
    assign EX_rt_data  = ex_q.rt_data;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: table-driven decode vectors plus
// hand-written sequences for interlock, stall/flush, bypass and reset.
module tb_instruction_decode;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [2:0]  alu;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        src;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rsd;
        logic [31:0] rtd;
    } ex_t;

    typedef struct {
        logic [31:0] instr;
        ex_t         exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        ID_reset = 1'b1;
    logic        IF_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        ID_stall = 1'b0;
    logic        ID_flush = 1'b0;
    logic        RF_WE = 1'b0;
    logic [4:0]  RF_waddr = '0;
    logic [31:0] RF_wdata = '0;
    logic [31:0] EX_rs_data, EX_rt_data, EX_imm;
    logic [4:0]  EX_rs, EX_rt, EX_dest;
    logic [2:0]  EX_ALU_op;
    logic        EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch;
    logic        EX_ALUSrc, EX_illegal, Load_hazard;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_decode #(.DATA_W(32)) dut (
        .clk(clk), .ID_reset(ID_reset), .IF_valid(IF_valid), .instruction(instruction),
        .ID_stall(ID_stall), .ID_flush(ID_flush), .RF_WE(RF_WE), .RF_waddr(RF_waddr),
        .RF_wdata(RF_wdata), .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data),
        .EX_imm(EX_imm), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_dest(EX_dest),
        .EX_ALU_op(EX_ALU_op), .EX_valid(EX_valid), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_Branch(EX_Branch),
        .EX_ALUSrc(EX_ALUSrc), .EX_illegal(EX_illegal), .Load_hazard(Load_hazard)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic ex_t mk(input logic v, input logic il, input logic [2:0] alu,
                               input logic rw, input logic mr, input logic mw,
                               input logic br, input logic src, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d,
                               input logic [31:0] im, input logic [31:0] sd,
                               input logic [31:0] td);
        ex_t e;
        e = '{valid: v, illegal: il, alu: alu, rw: rw, mr: mr, mw: mw, br: br, src: src,
              rs: s, rt: t, dest: d, imm: im, rsd: sd, rtd: td};
        return e;
    endfunction

    function automatic ex_t cap();
        return mk(EX_valid, EX_illegal, EX_ALU_op, EX_RegWrite, EX_MemRead, EX_MemWrite,
                  EX_Branch, EX_ALUSrc, EX_rs, EX_rt, EX_dest, EX_imm, EX_rs_data,
                  EX_rt_data);
    endfunction

    // Valid, illegal and control fields only (operands/indices masked)
    function automatic ex_t ctrl_only(input ex_t e);
        ex_t c;
        c = '0;
        c.valid = e.valid; c.illegal = e.illegal; c.alu = e.alu; c.rw = e.rw;
        c.mr = e.mr; c.mw = e.mw; c.br = e.br; c.src = e.src;
        return c;
    endfunction

    task automatic check_ex(input string name, input ex_t got, input ex_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        IF_valid = 1'b0; RF_WE = 1'b1; RF_waddr = a; RF_wdata = d;
        step();
        RF_WE = 1'b0;
    endtask

    vec_t vecs[13];
    ex_t  held;
    logic [31:0] byp_exp;

    initial begin
        // Register state used by the table: r1=0x10, r2=0x12345678, others 0
        vecs[0]  = '{i_type(6'h08, 5'd0, 5'd1, 16'hFFFC),
                     mk(1, 0, 3'd0, 1, 0, 0, 0, 1, 5'd0, 5'd1, 5'd1, 32'hFFFFFFFC,
                        32'h0, 32'h10)};
        vecs[1]  = '{r_type(5'd2, 5'd2, 5'd3, 6'h20),
                     mk(1, 0, 3'd0, 1, 0, 0, 0, 0, 5'd2, 5'd2, 5'd3, 32'h00001820,
                        32'h12345678, 32'h12345678)};
        vecs[2]  = '{r_type(5'd1, 5'd2, 5'd4, 6'h22),
                     mk(1, 0, 3'd1, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd4, 32'h00002022,
                        32'h10, 32'h12345678)};
        vecs[3]  = '{r_type(5'd2, 5'd1, 5'd5, 6'h24),
                     mk(1, 0, 3'd2, 1, 0, 0, 0, 0, 5'd2, 5'd1, 5'd5, 32'h00002824,
                        32'h12345678, 32'h10)};
        vecs[4]  = '{r_type(5'd1, 5'd2, 5'd6, 6'h25),
                     mk(1, 0, 3'd3, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd6, 32'h00003025,
                        32'h10, 32'h12345678)};
        vecs[5]  = '{r_type(5'd1, 5'd2, 5'd8, 6'h2A),
                     mk(1, 0, 3'd4, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd8, 32'h0000402A,
                        32'h10, 32'h12345678)};
        vecs[6]  = '{i_type(6'h23, 5'd1, 5'd5, 16'h0008),
                     mk(1, 0, 3'd0, 1, 1, 0, 0, 1, 5'd1, 5'd5, 5'd5, 32'h00000008,
                        32'h10, 32'h0)};
        vecs[7]  = '{i_type(6'h2B, 5'd1, 5'd2, 16'hFFF8),
                     mk(1, 0, 3'd0, 0, 0, 1, 0, 1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8,
                        32'h10, 32'h12345678)};
        vecs[8]  = '{i_type(6'h04, 5'd1, 5'd2, 16'h0003),
                     mk(1, 0, 3'd1, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'h00000003,
                        32'h10, 32'h12345678)};
        vecs[9]  = '{i_type(6'h3F, 5'd1, 5'd2, 16'h1234),
                     mk(1, 1, 3'd0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0, 32'h00001234,
                        32'h10, 32'h12345678)};
        vecs[10] = '{r_type(5'd1, 5'd2, 5'd3, 6'h21),
                     mk(1, 1, 3'd0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0, 32'h00001821,
                        32'h10, 32'h12345678)};
        vecs[11] = '{i_type(6'h08, 5'd2, 5'd9, 16'h7FFF),
                     mk(1, 0, 3'd0, 1, 0, 0, 0, 1, 5'd2, 5'd9, 5'd9, 32'h00007FFF,
                        32'h12345678, 32'h0)};
        // r0 was written with 0xDEADBEEF and must still read 0
        vecs[12] = '{r_type(5'd0, 5'd0, 5'd3, 6'h20),
                     mk(1, 0, 3'd0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd3, 32'h00001820,
                        32'h0, 32'h0)};

        // Reset
        ID_reset = 1'b1;
        step();
        step();
        check_ex("reset_outputs", cap(), '0);
        check_val("reset_hazard", {63'd0, Load_hazard}, 64'd0);
        ID_reset = 1'b0;

        wb(5'd1, 32'h10);
        wb(5'd2, 32'h12345678);
        wb(5'd0, 32'hDEADBEEF);
        wb(5'd7, 32'h55);

        // Table-driven decode, a bubble between vectors
        for (int i = 0; i < 13; i++) begin
            instruction = vecs[i].instr;
            IF_valid = 1'b1;
            step();
            check_ex($sformatf("vec%0d", i), cap(), vecs[i].exp);
            IF_valid = 1'b0;
            step();
            check_ex($sformatf("vec%0d_bubble", i), ctrl_only(cap()), '0);
        end

        // Load-use: LW r5,0(r1) then ADD r6,r5,r1
        IF_valid = 1'b1;
        instruction = i_type(6'h23, 5'd1, 5'd5, 16'h0000);
        #1;
        check_val("lw_no_hazard", {63'd0, Load_hazard}, 64'd0);
        step();
        instruction = r_type(5'd5, 5'd1, 5'd6, 6'h20);
        #1;
        check_val("lu_hazard", {63'd0, Load_hazard}, 64'd1);
        step();
        check_ex("lu_bubble", ctrl_only(cap()), '0);
        check_val("lu_hazard_drop", {63'd0, Load_hazard}, 64'd0);
        step();
        check_ex("lu_add_latched", cap(),
                 mk(1, 0, 3'd0, 1, 0, 0, 0, 0, 5'd5, 5'd1, 5'd6, 32'h00003020,
                    32'h0, 32'h10));

        // Hazard via rt only when the opcode reads rt; dest r0 never hazards
        instruction = i_type(6'h23, 5'd1, 5'd5, 16'h0000);
        step();
        instruction = i_type(6'h2B, 5'd1, 5'd5, 16'h0004);
        #1;
        check_val("sw_rt_hazard", {63'd0, Load_hazard}, 64'd1);
        instruction = i_type(6'h08, 5'd1, 5'd5, 16'h0001);
        #1;
        check_val("addi_rt_no_hazard", {63'd0, Load_hazard}, 64'd0);
        IF_valid = 1'b0;
        instruction = r_type(5'd5, 5'd1, 5'd6, 6'h20);
        #1;
        check_val("if_invalid_no_hazard", {63'd0, Load_hazard}, 64'd0);
        IF_valid = 1'b1;
        instruction = i_type(6'h23, 5'd1, 5'd0, 16'h0000);
        step();
        instruction = r_type(5'd0, 5'd0, 5'd6, 6'h20);
        #1;
        check_val("lw_r0_no_hazard", {63'd0, Load_hazard}, 64'd0);

        // Stall holds the register for three cycles
        instruction = r_type(5'd2, 5'd2, 5'd3, 6'h20);
        step();
        held = mk(1, 0, 3'd0, 1, 0, 0, 0, 0, 5'd2, 5'd2, 5'd3, 32'h00001820,
                  32'h12345678, 32'h12345678);
        check_ex("pre_stall", cap(), held);
        ID_stall = 1'b1;
        instruction = r_type(5'd1, 5'd2, 5'd4, 6'h22);
        for (int i = 0; i < 3; i++) begin
            step();
            check_ex($sformatf("stall_hold%0d", i), cap(), held);
        end

        // Hazard still evaluated while stalled, then flush beats stall
        ID_stall = 1'b0;
        instruction = i_type(6'h23, 5'd1, 5'd5, 16'h0000);
        step();
        ID_stall = 1'b1;
        instruction = r_type(5'd5, 5'd1, 5'd6, 6'h20);
        #1;
        check_val("stall_hazard", {63'd0, Load_hazard}, 64'd1);
        step();
        check_val("stall_keeps_lw", {62'd0, EX_valid, EX_MemRead}, 64'd3);
        ID_flush = 1'b1;
        step();
        check_ex("flush_over_stall", ctrl_only(cap()), '0);
        ID_flush = 1'b0;
        ID_stall = 1'b0;

        // Flush clears a latched illegal
        instruction = 32'hFC000000;
        step();
        check_ex("illegal_3f", ctrl_only(cap()),
                 mk(1, 1, 3'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0));
        ID_flush = 1'b1;
        step();
        check_ex("flush_clears_illegal", ctrl_only(cap()), '0);
        ID_flush = 1'b0;

        // Same-cycle write-back of r7 while reading r7
        instruction = r_type(5'd7, 5'd7, 5'd10, 6'h20);
        RF_WE = 1'b1; RF_waddr = 5'd7; RF_wdata = 32'hAA;
`ifdef ID_BYPASS_EN
        byp_exp = 32'hAA;
`else
        byp_exp = 32'h55;
`endif
        step();
        RF_WE = 1'b0;
        check_val("same_cycle_read", {EX_rs_data, EX_rt_data}, {byp_exp, byp_exp});
        step();
        check_val("after_write_read", {EX_rs_data, EX_rt_data}, {32'hAA, 32'hAA});

        // Reset mid-stream with a write-back attempt
        instruction = i_type(6'h08, 5'd0, 5'd1, 16'hFFFC);
        step();
        check_val("pre_reset_valid", {63'd0, EX_valid}, 64'd1);
        ID_reset = 1'b1;
        RF_WE = 1'b1; RF_waddr = 5'd2; RF_wdata = 32'hFFFF0000;
        step();
        check_ex("midstream_reset", cap(), '0);
        ID_reset = 1'b0;
        RF_WE = 1'b0;
        instruction = r_type(5'd2, 5'd1, 5'd3, 6'h20);
        step();
        check_val("rf_cleared_we_ignored", {EX_rs_data, EX_rt_data}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register and operand width.
REQ-002 SHALL have port clk  input  1  the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port ID_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port IF_valid  input  1  the instruction input is valid this cycle.
REQ-005 SHALL have port instruction  input  32  the fetched word from the fetch stage.
REQ-006 SHALL have ports ID_stall, ID_flush  input  1 each  downstream hold and kill requests.
REQ-007 SHALL have ports RF_WE  input  1, RF_waddr  input  5, RF_wdata  input  DATA_W  the write-back port.
REQ-008 SHALL have ports EX_rs_data, EX_rt_data, EX_imm  output  DATA_W each  registered operands and sign-extended immediate.
REQ-009 SHALL have ports EX_rs, EX_rt, EX_dest  output  5 each  registered register indices.
REQ-010 SHALL have ports EX_ALU_op  output  3, EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_ALUSrc, EX_illegal  output  1 each.
REQ-011 SHALL have port Load_hazard  output  1  combinational request for fetch to hold the PC and the instruction.

Function
REQ-012 SHALL decode fields as opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
REQ-013 SHALL implement R-type (opcode 0) with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A; dest=rd; RegWrite=1; ALUSrc=0.
REQ-014 SHALL implement LW 0x23 (MemRead, RegWrite, dest=rt), SW 0x2B (MemWrite), ADDI 0x08 (RegWrite, dest=rt), BEQ 0x04 (Branch); ALUSrc=1 for LW, SW and ADDI.
REQ-015 SHALL encode ALU_op as ADD=0, SUB=1, AND=2, OR=3, SLT=4; LW, SW and ADDI use ADD; BEQ uses SUB.
REQ-016 SHALL sign-extend imm[15] into EX_imm, for example 0xFFFC -> 0xFFFFFFFC.
REQ-017 SHALL hold a 32-entry DATA_W register file with asynchronous reads and a write on the clk edge when RF_WE=1.
REQ-018 SHALL keep register 0 reading as 0; writes to address 0 are discarded.
REQ-019 SHALL latch the ID/EX output register exactly one clk edge after a valid instruction, giving latency 1.
REQ-020 SHALL treat an unknown opcode or funct as illegal: EX_illegal=1, EX_valid=1, all control outputs 0.
REQ-021 SHALL assert Load_hazard when EX_valid & EX_MemRead & EX_dest!=0 & (EX_dest==rs | (EX_dest==rt & the opcode reads rt)) & IF_valid.
REQ-022 SHALL latch a bubble when Load_hazard=1: EX_valid=0 and all control outputs 0; the instruction is re-presented by fetch on the next cycle.
REQ-023 SHALL latch a bubble and clear EX_illegal when ID_flush=1.
REQ-024 SHALL leave the ID/EX register unchanged while ID_stall=1 and ID_flush=0; Load_hazard SHALL still be evaluated.
REQ-025 SHALL apply priority ID_reset > ID_flush > ID_stall > Load_hazard > normal latch.
REQ-026 SHALL latch a bubble when IF_valid=0 and no higher-priority condition is active.
REQ-027 SHALL perform register-file writes regardless of stall, flush or hazard.

Reset
REQ-028 SHALL clear every output to 0 and every register-file entry to 0 on a clk edge with ID_reset=1.
REQ-029 SHALL abandon any in-flight instruction when ID_reset is asserted mid-operation, with no partial update.
REQ-030 SHALL ignore RF_WE during a reset cycle.

Configuration
REQ-031 SHALL, with macro ID_BYPASS_EN defined, forward RF_wdata to a read port in the same cycle as RF_WE=1 on a matching nonzero address.
REQ-032 SHALL, with ID_BYPASS_EN undefined, return the pre-write register contents for a same-cycle read; the software or the hazard logic of the enclosing pipeline then covers this case.

Verification
REQ-033 SHALL check: reset, then ADDI r1,r0,-4 (0x2001FFFC) -> next edge EX_imm=0xFFFFFFFC, EX_dest=1, EX_ALUSrc=1, EX_RegWrite=1, EX_ALU_op=0.
REQ-034 SHALL check: write r2=0x12345678 via WB, then ADD r3,r2,r2 -> EX_rs_data=EX_rt_data=0x12345678; a write to r0 keeps r0 reading 0.
REQ-035 SHALL check: LW r5,0(r1) followed by ADD r6,r5,r1 -> Load_hazard=1 for one cycle, then a bubble (EX_valid=0), then the ADD latches.
REQ-036 SHALL check: ID_stall=1 for 3 cycles holds all EX outputs; ID_flush together with ID_stall -> bubble on the next edge.
REQ-037 SHALL check: same-cycle WB of r7=0xAA with a read of r7 -> 0xAA with ID_BYPASS_EN, the old value without it.
REQ-038 SHALL check: opcode 0x3F -> EX_illegal=1 with all controls 0; ID_reset asserted mid-stream -> all outputs 0 on the next edge.
